// File: rtl/spi_master_multi_if.sv
// Command/response stream and SPI pin bundle for spi_master_multi.
// The master modport is the SPI master's view; the slave modport is the attached environment's view.
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int SS_W   = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [SS_W-1:0]   cmd_ss;
  logic              cmd_cpol;
  logic              cmd_cpha;
  logic              cmd_hold;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              spi_MISO;
  logic              spi_MOSI;
  logic              spi_SCLK;
  logic [NUM_SS-1:0] spi_SS_n;

  modport master (
    input  cmd_valid, cmd_data, cmd_ss, cmd_cpol, cmd_cpha, cmd_hold, spi_MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, spi_MOSI, spi_SCLK, spi_SS_n
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_ss, cmd_cpol, cmd_cpha, cmd_hold, spi_MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, spi_MOSI, spi_SCLK, spi_SS_n
  );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: per-command CPOL/CPHA, multiple slave selects and
// chip-select hold across multi-word frames. Single clock domain.
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 4,
  parameter int CLK_DIV = 4,
  parameter int SS_W    = 3
) (
  input logic                clk_clk,
  input logic                reset_reset,
  spi_master_multi_if.master bus
);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] GUARD = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_SS-1:0] ssn_q, ssn_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              cmd_ready, accept, tick, last, start;
  logic [EDGE_W-1:0] nedge;

  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] s);
    logic [NUM_SS-1:0] d;
    for (int unsigned i = 0; i < NUM_SS; i++) d[i] = (s != SS_W'(i));
    return d;
  endfunction

  assign cmd_ready = (state_q == IDLE) || (state_q == HOLD);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign last      = (edge_q == EDGE_W'(2 * DATA_W));
  assign nedge     = edge_q + EDGE_W'(1);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    edge_d      = edge_q;
    shift_d     = shift_q;
    ss_d        = ss_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ssn_d       = ssn_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    start       = 1'b0;

    if (accept) begin
      shift_d = bus.cmd_data;
      ss_d    = bus.cmd_ss;
      cpol_d  = bus.cmd_cpol;
      cpha_d  = bus.cmd_cpha;
      hold_d  = bus.cmd_hold;
    end

    case (state_q)
      IDLE: start = accept;
      HOLD: begin
        if (accept) begin
          if (bus.cmd_ss == ss_q) begin
            start = 1'b1;
          end else begin
            // Slave change while held: release SS for a guard period, command stays pending.
            pend_d  = 1'b1;
            ssn_d   = '1;
            div_d   = '0;
            edge_d  = '0;
            state_d = GUARD;
          end
        end
      end
      SETUP, XFER: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (last) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_q;
            if (hold_q) begin
              state_d = HOLD;
            end else begin
              ssn_d   = '1;
              state_d = GUARD;
            end
          end else begin
            // One shift register serves both directions: TX leaves the MSB, RX enters the LSB.
            state_d = XFER;
            edge_d  = nedge;
            sclk_d  = ~sclk_q;
            if (nedge[0] ^ cpha_q)
              shift_d = {shift_q[DATA_W-2:0], bus.spi_MISO};
            else if (nedge != EDGE_W'(2 * DATA_W))
              mosi_d = shift_q[DATA_W-1];
          end
        end
      end
      GUARD: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (pend_q) begin
            start  = 1'b1;
            pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SETUP;
      div_d   = '0;
      edge_d  = '0;
      ssn_d   = ss_decode(accept ? bus.cmd_ss : ss_q);
      sclk_d  = accept ? bus.cmd_cpol : cpol_q;
      mosi_d  = accept ? bus.cmd_data[DATA_W-1] : shift_q[DATA_W-1];
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      edge_q      <= '0;
      shift_q     <= '0;
      ss_q        <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      hold_q      <= 1'b0;
      pend_q      <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ssn_q       <= '1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      edge_q      <= edge_d;
      shift_q     <= shift_d;
      ss_q        <= ss_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ssn_q       <= ssn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.spi_SCLK  = sclk_q;
  assign bus.spi_MOSI  = mosi_q;
  assign bus.spi_SS_n  = ssn_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed self-checking bench for spi_master_multi (DATA_W=8, NUM_SS=4, CLK_DIV=4).
// Sample index rel=k is the k-th falling clock edge after the accepting rising edge.
module tb_spi_master_multi;
  logic clk = 1'b0;
  logic reset_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       loopback = 1'b1;
  logic [7:0] slave_word = '0;
  logic [7:0] mosi_hist = '0;
  int         rise_cnt = 0;
  int         base = 0;
  int         sidx;
  logic       slave_bit;

  spi_master_multi_if #(.DATA_W(8), .NUM_SS(4), .SS_W(3)) bus ();

  spi_master_multi #(.DATA_W(8), .NUM_SS(4), .CLK_DIV(4), .SS_W(3)) dut (
    .clk_clk    (clk),
    .reset_reset(reset_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Slave: shifts out slave_word MSB first, advancing on each rising SCLK; records MOSI there too.
  always @(posedge bus.spi_SCLK) begin
    mosi_hist <= {mosi_hist[6:0], bus.spi_MOSI};
    rise_cnt  <= rise_cnt + 1;
  end

  always_comb begin
    sidx      = rise_cnt - base;
    slave_bit = (sidx >= 0 && sidx < 8) ? slave_word[3'(7 - sidx)] : 1'b0;
  end

  assign bus.spi_MISO = loopback ? bus.spi_MOSI : slave_bit;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic xfer(input logic [7:0] d, input logic [2:0] ss, input logic cpol,
                      input logic cpha, input logic hold, input logic [7:0] sw,
                      input logic [7:0] exp_rsp, input logic [3:0] exp_ssn,
                      input int off, input logic keepv, input string tag);
    int n, e, cnt;
    int bad_ss, bad_clk, bad_rv, bad_rdy;
    logic [3:0] essn, g_ss, w_ss;
    logic esclk, g_clk, w_clk, erv, g_rv, w_rv;
    logic [1:0] erdy, g_rdy, w_rdy;
    logic [7:0] got_rsp;
    bad_ss = -1; bad_clk = -1; bad_rv = -1; bad_rdy = -1;
    g_ss = '0; w_ss = '0; g_clk = 0; w_clk = 0; g_rv = 0; w_rv = 0; g_rdy = '0; w_rdy = '0;
    got_rsp = '0;
    bus.cmd_data = d; bus.cmd_ss = ss; bus.cmd_cpol = cpol; bus.cmd_cpha = cpha;
    bus.cmd_hold = hold; bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=%b, required 1 within 200 cycles", tag, bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keepv) bus.cmd_valid = 1'b0;
    base = rise_cnt;
    slave_word = sw;
    for (int rel = 1; rel <= 69 + off; rel++) begin
      if (rel > 1) @(negedge clk);
      e    = rel - off;
      cnt  = (e >= 5) ? (((e - 5) / 4 + 1 > 16) ? 16 : (e - 5) / 4 + 1) : 0;
      esclk = cpol ^ cnt[0];
      essn = (e <= 0) ? 4'hF : (e <= 68) ? exp_ssn : (hold ? exp_ssn : 4'hF);
      erv  = (e == 69);
      erdy = {(e == 69) ? hold : 1'b0, 1'b1};
      if (bus.spi_SS_n !== essn && bad_ss < 0) begin bad_ss = rel; g_ss = bus.spi_SS_n; w_ss = essn; end
      if (bus.spi_SCLK !== esclk && bad_clk < 0) begin bad_clk = rel; g_clk = bus.spi_SCLK; w_clk = esclk; end
      if (bus.rsp_valid !== erv && bad_rv < 0) begin bad_rv = rel; g_rv = bus.rsp_valid; w_rv = erv; end
      if ({bus.cmd_ready, bus.busy} !== erdy && bad_rdy < 0) begin
        bad_rdy = rel; g_rdy = {bus.cmd_ready, bus.busy}; w_rdy = erdy;
      end
      if (rel == 69 + off) got_rsp = bus.rsp_data;
    end
    checks++;
    if (bad_ss >= 0) begin errors++; $display("FAIL %s ss_n rel %0d: got %b required %b", tag, bad_ss, g_ss, w_ss); end
    checks++;
    if (bad_clk >= 0) begin errors++; $display("FAIL %s sclk rel %0d: got %b required %b", tag, bad_clk, g_clk, w_clk); end
    checks++;
    if (bad_rv >= 0) begin errors++; $display("FAIL %s rsp_valid rel %0d: got %b required %b", tag, bad_rv, g_rv, w_rv); end
    checks++;
    if (bad_rdy >= 0) begin errors++; $display("FAIL %s ready/busy rel %0d: got %b required %b", tag, bad_rdy, g_rdy, w_rdy); end
    checks++;
    if (got_rsp !== exp_rsp) begin errors++; $display("FAIL %s rsp_data: got %h required %h", tag, got_rsp, exp_rsp); end
  endtask

  // Called right after a non-held word's rsp_valid sample: three more guard cycles, then IDLE.
  task automatic check_guard(input string tag);
    int bad;
    logic [5:0] got, want, g, w;
    bad = -1; g = '0; w = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      got  = {bus.spi_SS_n, bus.cmd_ready, bus.busy};
      want = (k == 4) ? {4'hF, 1'b1, 1'b0} : {4'hF, 1'b0, 1'b1};
      if (got !== want && bad < 0) begin bad = k; g = got; w = want; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s guard +%0d {ss_n,ready,busy}: got %b required %b", tag, bad, g, w);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_ss = '0;
    bus.cmd_cpol = 1'b0; bus.cmd_cpha = 1'b0; bus.cmd_hold = 1'b0;
    #3 reset_reset = 1'b1;
    #1;
    checks++;
    if ({bus.spi_SS_n, bus.spi_SCLK, bus.spi_MOSI, bus.rsp_valid, bus.cmd_ready, bus.busy} !== 9'b1111_0_0_0_1_0) begin
      errors++;
      $display("FAIL reset outputs {ss_n,sclk,mosi,rv,ready,busy}: got %b required 111100010",
               {bus.spi_SS_n, bus.spi_SCLK, bus.spi_MOSI, bus.rsp_valid, bus.cmd_ready, bus.busy});
    end
    checks++;
    if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL reset rsp_data: got %h required 00", bus.rsp_data); end
    @(negedge clk); @(negedge clk);
    reset_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    loopback = 1'b1;
    xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 4'b1110, 0, 1'b0, "mode0");
    check_guard("mode0");
  endtask

  task automatic test_mode3();
    loopback = 1'b0;
    xfer(8'hF0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 4'b1011, 0, 1'b0, "mode3");
    checks++;
    if (mosi_hist !== 8'hF0) begin errors++; $display("FAIL mode3 mosi at rising sclk: got %h required f0", mosi_hist); end
    check_guard("mode3");
  endtask

  task automatic test_hold_same();
    loopback = 1'b0;
    xfer(8'h5A, 3'd1, 1'b0, 1'b0, 1'b1, 8'hC3, 8'hC3, 4'b1101, 0, 1'b0, "hold_w1");
    xfer(8'h96, 3'd1, 1'b0, 1'b0, 1'b0, 8'h7E, 8'h7E, 4'b1101, 0, 1'b0, "hold_w2");
    checks++;
    if (mosi_hist !== 8'h96) begin errors++; $display("FAIL hold_w2 mosi: got %h required 96", mosi_hist); end
    check_guard("hold_w2");
  endtask

  task automatic test_hold_switch();
    loopback = 1'b0;
    xfer(8'h11, 3'd0, 1'b0, 1'b0, 1'b1, 8'h22, 8'h22, 4'b1110, 0, 1'b0, "switch_w1");
    xfer(8'h33, 3'd3, 1'b0, 1'b0, 1'b0, 8'h44, 8'h44, 4'b0111, 4, 1'b0, "switch_w2");
    check_guard("switch_w2");
  endtask

  task automatic test_bad_ss();
    loopback = 1'b1;
    xfer(8'h69, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h69, 4'b1111, 0, 1'b0, "bad_ss");
    check_guard("bad_ss");
  endtask

  task automatic test_back_to_back();
    loopback = 1'b1;
    xfer(8'hC3, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 4'b1110, 0, 1'b1, "held_valid_w1");
    check_guard("held_valid_w1");
    xfer(8'h3E, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3E, 4'b1110, 0, 1'b0, "held_valid_w2");
    check_guard("held_valid_w2");
  endtask

  task automatic test_reset_midxfer();
    int n, pulses;
    loopback = 1'b1;
    bus.cmd_data = 8'hA5; bus.cmd_ss = 3'd0; bus.cmd_cpol = 1'b0; bus.cmd_cpha = 1'b0;
    bus.cmd_hold = 1'b0; bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (28) @(negedge clk);
    checks++;
    if (bus.spi_SCLK !== 1'b1 || bus.spi_SS_n !== 4'b1110) begin
      errors++;
      $display("FAIL midxfer pre-reset {sclk,ss_n}: got %b required 11110", {bus.spi_SCLK, bus.spi_SS_n});
    end
    @(posedge clk);
    #2 reset_reset = 1'b1;
    #1;
    checks++;
    if ({bus.spi_SS_n, bus.spi_SCLK, bus.spi_MOSI, bus.rsp_valid, bus.cmd_ready, bus.busy} !== 9'b1111_0_0_0_1_0) begin
      errors++;
      $display("FAIL midxfer reset outputs {ss_n,sclk,mosi,rv,ready,busy}: got %b required 111100010",
               {bus.spi_SS_n, bus.spi_SCLK, bus.spi_MOSI, bus.rsp_valid, bus.cmd_ready, bus.busy});
    end
    checks++;
    if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL midxfer reset rsp_data: got %h required 00", bus.rsp_data); end
    @(negedge clk); @(negedge clk);
    reset_reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midxfer aborted rsp_valid pulses: got %0d required 0", pulses); end
    xfer(8'h3C, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 4'b1110, 0, 1'b0, "after_reset");
    check_guard("after_reset");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_hold_same();
    test_hold_switch();
    test_bad_ss();
    test_back_to_back();
    test_reset_midxfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
